pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues word fetches over a req/ready
// handshake, presents instr/pc/pc+4 downstream, and absorbs redirects at any time.
module pc_fetch_unit #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic            misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   pend_pc, pend_pc_next;
  logic              instr_valid_next;
  logic [31:0]       instr_next;
  logic [XLEN-1:0]   instr_pc_next, instr_pc_plus4_next;
  logic              misalign_next;
  logic              slot_free;
  logic [XLEN-1:0]   aligned_target;

  // A fetch is only issued when the output slot can take its result next cycle.
  assign slot_free      = !instr_valid || instr_ready;
  assign imem_req       = ((state == FETCH) && slot_free) || (state == DRAIN);
  assign imem_addr      = pc;
  assign aligned_target = {redirect_target[XLEN-1:2], 2'b00};

  // Next-state, next-pc and output-slot decode.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    pend_pc_next        = pend_pc;
    instr_valid_next    = instr_valid;
    instr_next          = instr;
    instr_pc_next       = instr_pc;
    instr_pc_plus4_next = instr_pc_plus4;
    misalign_next       = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          misalign_next    = (redirect_target[1:0] != 2'b00);
          instr_valid_next = 1'b0;
          if (imem_req && !imem_ready) begin
            pend_pc_next = aligned_target;
            state_next   = DRAIN;
          end else begin
            pc_next    = aligned_target;
            state_next = FETCH;
          end
        end else if (!imem_req) begin
          state_next = HOLD;
        end else if (imem_ready) begin
          instr_next          = imem_rdata;
          instr_pc_next       = pc;
          instr_pc_plus4_next = pc + XLEN'(4);
          instr_valid_next    = 1'b1;
          pc_next             = pc + XLEN'(4);
          state_next          = FETCH;
        end else if (instr_ready) begin
          instr_valid_next = 1'b0;
        end else begin
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          misalign_next    = (redirect_target[1:0] != 2'b00);
          instr_valid_next = 1'b0;
          pc_next          = aligned_target;
          state_next       = FETCH;
        end else if (instr_ready) begin
          instr_valid_next = 1'b0;
          state_next       = FETCH;
        end else begin
          state_next = HOLD;
        end
      end
      DRAIN: begin
        // The wrong-path response is dropped; the latest redirect target wins.
        if (redirect_valid) begin
          misalign_next = (redirect_target[1:0] != 2'b00);
          if (imem_ready) begin
            pc_next    = aligned_target;
            state_next = FETCH;
          end else begin
            pend_pc_next = aligned_target;
          end
        end else if (imem_ready) begin
          pc_next    = pend_pc;
          state_next = FETCH;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      pend_pc        <= '0;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= '0;
      instr_pc_plus4 <= '0;
      misalign_err   <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pend_pc        <= pend_pc_next;
      instr_valid    <= instr_valid_next;
      instr          <= instr_next;
      instr_pc       <= instr_pc_next;
      instr_pc_plus4 <= instr_pc_plus4_next;
      misalign_err   <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, every cycle checked
// against a rule-level model; a second instance reset at FFFF_FFFC checks wrap-around.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_ready = 1'b0;

  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, instr_pc, instr_pc_plus4;
  logic        w_imem_req, w_instr_valid, w_misalign_err;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc, w_instr_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the unit's architectural behaviour.
  logic [31:0] m_pc, m_pend, m_instr, m_ipc;
  logic        m_known = 1'b0;
  logic        m_boot, m_wrong, m_blocked, m_v, m_mis, m_same;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .misalign_err(misalign_err)
  );

  pc_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_pc_plus4(w_instr_pc_plus4), .misalign_err(w_misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // A fetch may go out unless we just left reset, or the slot is full and stays full.
  function automatic logic exp_req(input logic ordy);
    if (m_boot) return 1'b0;
    if (m_wrong) return 1'b1;
    if (m_blocked) return 1'b0;
    return !m_v || ordy;
  endfunction

  task automatic step(input logic s_rst, input logic s_rv, input logic [31:0] s_tgt,
                      input logic s_ir, input logic s_or);
    logic        e_req;
    logic [31:0] at;
    @(negedge clk);
    rst = s_rst; redirect_valid = s_rv; redirect_target = s_tgt;
    imem_ready = s_ir; instr_ready = s_or; imem_rdata = $urandom();
    #1;
    e_req = exp_req(s_or);
    if (m_known) begin
      chk1("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk1("instr_valid", instr_valid, m_v);
      chk1("misalign_err", misalign_err, m_mis);
      if (m_v) begin
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("instr_pc_plus4", instr_pc_plus4, m_ipc + 32'd4);
      end
      if (m_same) begin
        chk1("wrap_req", w_imem_req, e_req);
        if (e_req) chk("wrap_addr", w_imem_addr, m_pc + WRAP_PC);
        chk1("wrap_valid", w_instr_valid, m_v);
        chk1("wrap_misalign", w_misalign_err, m_mis);
        if (m_v) begin
          chk("wrap_instr", w_instr, m_instr);
          chk("wrap_instr_pc", w_instr_pc, m_ipc + WRAP_PC);
          chk("wrap_plus4", w_instr_pc_plus4, m_ipc + WRAP_PC + 32'd4);
        end
      end
    end
    @(posedge clk);
    at = {s_tgt[31:2], 2'b00};
    if (s_rst) begin
      m_known = 1'b1; m_boot = 1'b1; m_pc = 32'd0; m_pend = 32'd0; m_wrong = 1'b0;
      m_blocked = 1'b0; m_v = 1'b0; m_mis = 1'b0; m_instr = NOP; m_ipc = 32'd0; m_same = 1'b1;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot = 1'b0;
        m_mis  = 1'b0;
      end else begin
        m_mis = s_rv && (s_tgt[1:0] != 2'b00);
        if (s_rv) m_same = 1'b0;
        if (m_wrong) begin
          if (s_rv && s_ir) begin m_pc = at; m_wrong = 1'b0; end
          else if (s_rv) m_pend = at;
          else if (s_ir) begin m_pc = m_pend; m_wrong = 1'b0; end
        end else if (s_rv) begin
          m_v = 1'b0; m_blocked = 1'b0;
          if (e_req && !s_ir) begin m_pend = at; m_wrong = 1'b1; end
          else m_pc = at;
        end else if (m_blocked) begin
          if (s_or) begin m_v = 1'b0; m_blocked = 1'b0; end
        end else if (!e_req) begin
          m_blocked = 1'b1;
        end else if (s_ir) begin
          m_instr = imem_rdata; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 32'd4;
        end else if (s_or) begin
          m_v = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic        r_rst, r_rv, r_ir, r_or;
    logic [31:0] r_tgt;

    // Reset state
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_plus4", instr_pc_plus4, 32'd0);
    chk1("rst_misalign", misalign_err, 1'b0);

    // Back-to-back streaming, wrap instance crosses FFFF_FFFC -> 0
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk1("stream_valid", instr_valid, 1'b1);
    chk("stream_pc0", instr_pc, 32'd0);
    chk("wrap_first_pc", w_instr_pc, 32'hFFFF_FFFC);
    chk("wrap_first_plus4", w_instr_pc_plus4, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("stream_pc4", instr_pc, 32'd4);
    chk("wrap_second_pc", w_instr_pc, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Downstream stall after first delivery
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    #2;
    chk1("hold_req", imem_req, 1'b0);
    chk("hold_pc", instr_pc, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("resume_pc", instr_pc, 32'd4);

    // Memory stall at 8 with a redirect while pending
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    #2;
    chk("drain_addr", imem_addr, 32'd8);
    chk1("drain_req", imem_req, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("drain_next_addr", imem_addr, 32'h100);
    chk1("drain_no_valid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("target_pc", instr_pc, 32'h100);

    // Misaligned redirect
    step(1'b0, 1'b1, 32'h202, 1'b1, 1'b1);
    #2;
    chk1("misalign_pulse", misalign_err, 1'b1);
    chk("misalign_addr", imem_addr, 32'h200);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk1("misalign_clear", misalign_err, 1'b0);
    chk("misalign_pc", instr_pc, 32'h200);

    // Redirect coincident with completion at 4
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    #2;
    chk1("coinc_valid", instr_valid, 1'b0);
    chk("coinc_addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("coinc_pc", instr_pc, 32'h40);

    // Wrap on the default instance through a redirect near the top
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Reset in the middle of a drain
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    chk1("rst_drain_req", imem_req, 1'b0);
    chk("rst_drain_instr", instr, NOP);
    chk1("rst_drain_valid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #2;
    chk1("restart_valid", instr_valid, 1'b1);
    chk("restart_pc", instr_pc, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else r_tgt = $urandom();
      r_ir  = ($urandom_range(0, 2) != 0);
      r_or  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_rv, r_tgt, r_ir, r_or);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
